// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract over one 4-bit CLA, one nibble per clock, LSB first; NIB cycles accept-to-result.
// Backpressure: req_ready only in IDLE; result held in DONE until res_ready, no combinational ready paths.
module CLA (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = in1 & in2;
        p    = in1 ^ in2;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module cla_seq_adder #(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*NIB-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);
    localparam int W     = 4 * NIB;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               res_valid_q, res_valid_d;

    logic [3:0]         cla_in1, cla_in2, cla_sum;
    logic               cla_cout;
    logic               last_nib;

    CLA u_cla (
        .in1  (cla_in1),
        .in2  (cla_in2),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign last_nib = (cnt_q == CNT_W'(NIB - 1));

    always_comb begin
        cla_in1 = op_a_q[3:0];
        cla_in2 = op_b_q[3:0];
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                cla_in1 = op_a_q[4*i +: 4];
                cla_in2 = op_b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Subtract is A + ~B + ~borrow, so the same CLA path serves both.
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (cnt_q == CNT_W'(i)) sum_d[4*i +: 4] = cla_sum;
                end
                carry_d = cla_cout;
                if (last_nib) begin
                    cout_d      = cla_cout;
                    ovf_d       = (op_a_q[W-1] == op_b_q[W-1]) && (cla_sum[3] != op_a_q[W-1]);
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: NIB=4 instance for the main scenarios plus a NIB=1 instance.
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, res_valid, res_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf, busy;

    logic        n1_req_valid, n1_req_ready, n1_res_valid, n1_res_ready;
    logic [3:0]  n1_a, n1_b, n1_sum;
    logic        n1_cin, n1_sub, n1_cout, n1_ovf, n1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.NIB(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    cla_seq_adder #(.NIB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(n1_req_valid), .req_ready(n1_req_ready),
        .a(n1_a), .b(n1_b), .cin(n1_cin), .sub(n1_sub), .res_valid(n1_res_valid),
        .res_ready(n1_res_ready), .sum(n1_sum), .cout(n1_cout), .ovf(n1_ovf), .busy(n1_busy)
    );

    // Called #1 after a rising edge with the DUT idle; returns result and accept-to-valid latency.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub, output logic [15:0] os, output logic oc,
                          output logic oo, output int lat);
        res_ready = 1'b1;
        a = ia; b = ib; cin = icin; sub = isub;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        os = sum; oc = cout; oo = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL rst_sum got %h exp 0000", sum); end
        checks++; if ({cout, ovf, busy} !== 3'b000) begin errors++; $display("FAIL rst_cout_ovf_busy got %b exp 000", {cout, ovf, busy}); end
        checks++; if (n1_req_ready !== 1'b1 || n1_busy !== 1'b0) begin errors++; $display("FAIL rst_n1 got rdy=%b busy=%b exp 1/0", n1_req_ready, n1_busy); end
    endtask

    task automatic test_add;
        logic [15:0] va [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321};
        logic [15:0] es [4] = '{16'h0002, 16'h0000, 16'h8000, 16'h5555};
        logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] s; logic c, o; int lat;
        for (int k = 0; k < 4; k++) begin
            run_op(va[k], vb[k], 1'b0, 1'b0, s, c, o, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency got %0d exp 4", k, lat); end
            checks++; if (s !== es[k]) begin errors++; $display("FAIL add%0d_sum got %h exp %h", k, s, es[k]); end
            checks++; if ({c, o} !== {ec[k], eo[k]}) begin errors++; $display("FAIL add%0d_cout_ovf got %b exp %b", k, {c, o}, {ec[k], eo[k]}); end
            checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL add%0d_return_idle got rdy=%b vld=%b exp 1/0", k, req_ready, res_valid); end
        end
    endtask

    task automatic test_sub;
        logic [15:0] va [3] = '{16'h0005, 16'h0010, 16'h8000};
        logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h0001};
        logic        vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] es [3] = '{16'hFFFE, 16'h000E, 16'h7FFF};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] s; logic c, o; int lat;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], vc[k], 1'b1, s, c, o, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL sub%0d_latency got %0d exp 4", k, lat); end
            checks++; if (s !== es[k]) begin errors++; $display("FAIL sub%0d_sum got %h exp %h", k, s, es[k]); end
            checks++; if ({c, o} !== {ec[k], eo[k]}) begin errors++; $display("FAIL sub%0d_cout_ovf got %b exp %b", k, {c, o}, {ec[k], eo[k]}); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        res_ready = 1'b0;
        a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        // Operands change under RUN and req_valid stays high; neither may disturb this command.
        a = 16'hFFFF; b = 16'hFFFF;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", lat); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || sum !== 16'h0007 || cout !== 1'b0 || ovf !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got vld=%b sum=%h c=%b o=%b rdy=%b exp 1/0007/0/0/0", k, res_valid, sum, cout, ovf, req_ready);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_handshake got rdy=%b vld=%b busy=%b exp 1/0/0", req_ready, res_valid, busy); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_reaccept got busy=%b rdy=%b exp 1/0", busy, req_ready); end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (sum !== 16'hFFFE || cout !== 1'b1 || ovf !== 1'b0 || lat !== 4) begin errors++; $display("FAIL bp_second got sum=%h c=%b o=%b lat=%0d exp FFFE/1/0/4", sum, cout, ovf, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] s; logic c, o; int lat;
        bit seen;
        res_ready = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (sum[7:0] !== 8'h33) begin errors++; $display("FAIL rm_partial got %h exp low byte 33", sum); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || sum !== 16'h0) begin errors++; $display("FAIL rm_async got rdy=%b busy=%b vld=%b sum=%h exp 1/0/0/0000", req_ready, busy, res_valid, sum); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_result got res_valid seen=%b exp 0", seen); end
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, o, lat);
        checks++; if (s !== 16'h5555 || lat !== 4) begin errors++; $display("FAIL rm_after got sum=%h lat=%0d exp 5555/4", s, lat); end
    endtask

    task automatic test_nib1;
        int lat;
        n1_a = 4'hF; n1_b = 4'h1; n1_cin = 1'b1; n1_sub = 1'b0;
        n1_req_valid = 1'b1;
        @(posedge clk); #1;
        n1_req_valid = 1'b0;
        lat = 0;
        while (!n1_res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency got %0d exp 1", lat); end
        checks++; if (n1_sum !== 4'h1 || n1_cout !== 1'b1 || n1_ovf !== 1'b0) begin errors++; $display("FAIL n1_result got sum=%h c=%b o=%b exp 1/1/0", n1_sum, n1_cout, n1_ovf); end
        @(posedge clk); #1;
        checks++; if (n1_req_ready !== 1'b1) begin errors++; $display("FAIL n1_idle got rdy=%b exp 1", n1_req_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; res_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        n1_req_valid = 1'b0; n1_res_ready = 1'b1; n1_a = '0; n1_b = '0; n1_cin = 1'b0; n1_sub = 1'b0;
        #3;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add;
        test_sub;
        test_backpressure;
        test_reset_mid;
        test_nib1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-precision add/subtract sequencer built around the team's single 4-bit carry look-ahead adder (module CLA; ports in1, in2, cin, sum, cout).
- Accepts two NIB×4-bit operands over a valid/ready handshake.
- Feeds them to the CLA one nibble per clock, least-significant first, carrying the CLA carry-out forward in a register.
- Presents the full-width result over a second valid/ready handshake.
- Sits between a requester and the shared 4-bit CLA. It trades area for latency: one CLA instance serves any width.

## Interface
- NIB, 4, number of 4-bit nibbles; operand width W = 4·NIB; legal NIB ≥ 1.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  operands/command valid.
- req_ready  out  1  block can accept a command; high only in IDLE.
- a  in  W  operand A (unsigned/two's complement).
- b  in  W  operand B.
- cin  in  1  carry-in (add) / borrow-in (subtract).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  consumer accepts result.
- sum  out  W  result, registered.
- cout  out  1  final carry-out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow of the W-bit operation.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch a into op_a and (sub ? ~b : b) into op_b;
  - set the carry register to (sub ? ~cin : cin);
  - clear the nibble counter to 0;
  - go to RUN.
- RUN: the CLA receives in1=op_a[4i+3:4i], in2=op_b[4i+3:4i], cin=carry register, where i is the nibble counter. Each edge:
  - write CLA sum into sum[4i+3:4i];
  - load carry register ← CLA cout;
  - increment i.
- End of RUN: on the edge where i=NIB−1:
  - cout ← CLA cout;
  - ovf ← (op_a[W−1]==op_b[W−1]) && (result MSB ≠ op_a[W−1]);
  - go to DONE.
- DONE: res_valid=1; sum, cout and ovf held stable. On res_ready, go to IDLE and drop res_valid.
- Inputs a, b, cin and sub are sampled only on the accept edge. Changes during RUN/DONE have no effect.
- req_valid in RUN/DONE is ignored (req_ready=0). The requester must hold it until accepted.
- The nibble counter is $clog2(NIB) bits wide (1 bit when NIB=1), with no wrap past NIB−1.
- sum bits of nibbles not yet computed keep their previous values during RUN. sum is only meaningful while res_valid=1.
- Async reset, including mid-RUN or in DONE:
  - go to IDLE immediately;
  - any in-flight command is discarded and no result is produced.
- Reset values:
  - state IDLE; req_ready 1 (combinational from state);
  - res_valid 0; sum 0; cout 0; ovf 0; busy 0;
  - internal op_a, op_b, carry register and counter 0.

## Timing
- Accept edge t0. RUN occupies cycles t0+1 … t0+NIB.
- res_valid rises after edge t0+NIB, so latency is NIB cycles from accept to result.
- With res_ready held high, DONE lasts one cycle, and req_ready returns after edge t0+NIB+1.
- Minimum spacing between accepts is NIB+2 cycles (NIB=4: 6 cycles).
- No back-to-back accept in the DONE→IDLE cycle: req_ready is low in DONE even if res_ready=1.
- res_valid and result outputs are fully registered. req_ready and busy are decoded from state only, with no combinational path from req_valid or res_ready.
- The CLA path (one 4-bit CLA plus mux) is the only per-cycle combinational adder path.

## Test plan
- NIB=4. a=0x0001, b=0x0001, cin=0, sub=0 → sum=0x0002, cout=0, ovf=0. res_valid rises exactly 4 cycles after accept.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0 (borrow), ovf=0.
  - a=0x0010, b=0x0001, sub=1, cin=1 → sum=0x000E, cout=1.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Backpressure: hold res_ready=0 for 3 cycles in DONE → res_valid, sum, cout and ovf stable. A req_valid held throughout is not accepted until the cycle after the result handshake. Change a/b during RUN → result unaffected.
- Reset mid-operation: assert rst_n=0 when the counter is 2 → outputs go to reset values asynchronously and res_valid never rises for that command. A subsequent 0x1234+0x4321 yields 0x5555 in 4 cycles.
- NIB=1 build: a=0xF, b=0x1, cin=1 → sum=0x1, cout=1, res_valid 1 cycle after accept.
